// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: the two pipeline writeback sources, the multicycle
// result handshake, the two regfile write ports and the status outputs.
// The master drives the writeback sources; the slave is the arbiter itself.
interface regfile_wb_arbiter_if;
   logic        p_wen;
   logic [4:0]  p_waddr;
   logic [31:0] p_wdata;
   logic        i_wen;
   logic [4:0]  i_waddr;
   logic [31:0] i_wdata;
   logic        m_valid;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic        m_ready;
   logic        wen0;
   logic [4:0]  waddr0;
   logic [31:0] wdata0;
   logic        wen1;
   logic [4:0]  waddr1;
   logic [31:0] wdata1;
   logic        stall_req;
   logic        m_pending;

   modport master (
      output p_wen, p_waddr, p_wdata,
      output i_wen, i_waddr, i_wdata,
      output m_valid, m_waddr, m_wdata,
      input  m_ready,
      input  wen0, waddr0, wdata0,
      input  wen1, waddr1, wdata1,
      input  stall_req, m_pending
   );

   modport slave (
      input  p_wen, p_waddr, p_wdata,
      input  i_wen, i_waddr, i_wdata,
      input  m_valid, m_waddr, m_wdata,
      output m_ready,
      output wen0, waddr0, wdata0,
      output wen1, waddr1, wdata1,
      output stall_req, m_pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter: pipeline primary result owns port 0, increment
// result owns port 1, and a one-entry buffer holds multicycle results until
// a port is free. A result that waits MAX_WAIT cycles raises stall_req.
// Optional macro WB_ARB_FORWARD_EN: forward a multicycle result straight to a
// free port when the buffer is empty (zero latency).
module regfile_wb_arbiter #(
   parameter int unsigned MAX_WAIT = 8
) (
   input logic                 i_clk,
   input logic                 i_rst,
   regfile_wb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FORCE} state_t;

   localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      r_state;
   logic        r_buf_valid;
   logic [4:0]  r_buf_addr;
   logic [31:0] r_buf_data;
   logic [7:0]  r_wait_cnt;
   logic        r_stall;

   logic        w_drop;
   logic        w_drain0;
   logic        w_drain1;
   logic        w_consume;
   logic        w_fwd0;
   logic        w_fwd1;
   logic        w_m_ready;
   logic        w_capture;
   logic        w_wen0;
   logic [4:0]  w_waddr0;
   logic [31:0] w_wdata0;
   logic        w_wen1;
   logic [4:0]  w_waddr1;
   logic [31:0] w_wdata1;
   logic [7:0]  w_wait_inc;

   // Buffer drain/drop decisions and the multicycle handshake.
   always_comb begin
      // A newer pipeline write to the same register kills the older buffered
      // result; any same-address conflict with an active port implies a drop,
      // so a drain never duplicates the other port's address.
      w_drop    = !i_rst && r_buf_valid &&
                  ((bus.p_wen && (bus.p_waddr == r_buf_addr)) ||
                   (bus.i_wen && (bus.i_waddr == r_buf_addr)));
      w_drain0  = !i_rst && r_buf_valid && !w_drop && !bus.p_wen;
      w_drain1  = !i_rst && r_buf_valid && !w_drop && bus.p_wen && !bus.i_wen;
      w_consume = w_drop || w_drain0 || w_drain1;
      w_m_ready = !i_rst && (!r_buf_valid || w_consume);
`ifdef WB_ARB_FORWARD_EN
      w_fwd0    = !i_rst && !r_buf_valid && bus.m_valid && !bus.p_wen &&
                  !(bus.i_wen && (bus.i_waddr == bus.m_waddr));
      w_fwd1    = !i_rst && !r_buf_valid && bus.m_valid && bus.p_wen && !bus.i_wen &&
                  (bus.p_waddr != bus.m_waddr);
`else
      w_fwd0    = 1'b0;
      w_fwd1    = 1'b0;
`endif
      w_capture = bus.m_valid && w_m_ready && !w_fwd0 && !w_fwd1;
      w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
   end

   // Port muxes: pipeline sources pass through, buffer/forward fill idle ports.
   always_comb begin
      w_wen0   = bus.p_wen;
      w_waddr0 = bus.p_waddr;
      w_wdata0 = bus.p_wdata;
      w_wen1   = bus.i_wen;
      w_waddr1 = bus.i_waddr;
      w_wdata1 = bus.i_wdata;
      // r0 results are consumed but never written.
      if (w_drain0) begin
         w_wen0   = (r_buf_addr != 5'd0);
         w_waddr0 = r_buf_addr;
         w_wdata0 = r_buf_data;
      end else if (w_fwd0) begin
         w_wen0   = (bus.m_waddr != 5'd0);
         w_waddr0 = bus.m_waddr;
         w_wdata0 = bus.m_wdata;
      end
      if (w_drain1) begin
         w_wen1   = (r_buf_addr != 5'd0);
         w_waddr1 = r_buf_addr;
         w_wdata1 = r_buf_data;
      end else if (w_fwd1) begin
         w_wen1   = (bus.m_waddr != 5'd0);
         w_waddr1 = bus.m_waddr;
         w_wdata1 = bus.m_wdata;
      end
   end

   // Buffer and wait/stall state machine.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_buf_valid <= 1'b0;
         r_buf_addr  <= 5'd0;
         r_buf_data  <= 32'd0;
         r_wait_cnt  <= 8'd0;
         r_stall     <= 1'b0;
      end else begin
         r_buf_valid <= w_capture || (r_buf_valid && !w_consume);
         if (w_capture) begin
            r_buf_addr <= bus.m_waddr;
            r_buf_data <= bus.m_wdata;
         end
         case (r_state)
            S_IDLE: begin
               r_wait_cnt <= 8'd0;
               if (w_capture) r_state <= S_HOLD;
            end
            S_HOLD: begin
               if (w_consume) begin
                  r_state    <= w_capture ? S_HOLD : S_IDLE;
                  r_wait_cnt <= 8'd0;
               end else if (r_wait_cnt == LP_WAIT_LAST) begin
                  r_state    <= S_FORCE;
                  r_stall    <= 1'b1;
                  r_wait_cnt <= w_wait_inc;
               end else begin
                  r_wait_cnt <= w_wait_inc;
               end
            end
            S_FORCE: begin
               // Stay here until the pipeline frees a port.
               if (w_consume) begin
                  r_state    <= w_capture ? S_HOLD : S_IDLE;
                  r_stall    <= 1'b0;
                  r_wait_cnt <= 8'd0;
               end else begin
                  r_wait_cnt <= w_wait_inc;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_stall    <= 1'b0;
               r_wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   assign bus.m_ready   = w_m_ready;
   assign bus.wen0      = w_wen0;
   assign bus.waddr0    = w_waddr0;
   assign bus.wdata0    = w_wdata0;
   assign bus.wen1      = w_wen1;
   assign bus.waddr1    = w_waddr1;
   assign bus.wdata1    = w_wdata1;
   assign bus.stall_req = r_stall;
   assign bus.m_pending = r_buf_valid;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic.
// The driver runs a transaction-level model (a queue of waiting multicycle
// results with an age) and pushes expected per-cycle status and port writes;
// a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;
   localparam int MW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if bus();
   regfile_wb_arbiter #(.MAX_WAIT(MW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   typedef struct {logic [4:0] a; logic [31:0] d; int age;} item_t;
   typedef struct {bit rdy; bit stall; bit pend; bit w0; bit w1;} st_t;
   typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;

   item_t       mq[$];
   st_t         st_q[$];
   wr_t         q0[$];
   wr_t         q1[$];
   logic [31:0] rf[32];
   int          errors = 0;
   int          checks = 0;
   st_t         ms;
   wr_t         mw;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit model_stall();
      return (mq.size() > 0) && (mq[0].age >= MW);
   endfunction

   // One clock cycle of stimulus plus the reference model's view of it.
   task automatic cyc(input bit r,
                      input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                      input bit iw, input logic [4:0] ia, input logic [31:0] id,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md);
      st_t s;
      bit  cons = 0;
      bit  fwd  = 0;
      bit  pend;
      @(posedge clk); #1;
      rst = r;
      bus.p_wen = pw; bus.p_waddr = pa; bus.p_wdata = pd;
      bus.i_wen = iw; bus.i_waddr = ia; bus.i_wdata = id;
      bus.m_valid = mv; bus.m_waddr = ma; bus.m_wdata = md;
      pend    = mq.size() > 0;
      s.pend  = pend;
      s.stall = model_stall();
      s.w0    = pw;
      s.w1    = iw;
      if (pw) q0.push_back('{pa, pd});
      if (iw) q1.push_back('{ia, id});
      if (pend && !r) begin
         if ((pw && pa == mq[0].a) || (iw && ia == mq[0].a)) cons = 1;
         else if (!pw) begin
            cons = 1;
            if (mq[0].a != 0) begin s.w0 = 1; q0.push_back('{mq[0].a, mq[0].d}); end
         end else if (!iw) begin
            cons = 1;
            if (mq[0].a != 0) begin s.w1 = 1; q1.push_back('{mq[0].a, mq[0].d}); end
         end
      end
      s.rdy = !r && (!pend || cons);
`ifdef WB_ARB_FORWARD_EN
      if (!r && !pend && mv) begin
         if (!pw && !(iw && ia == ma)) begin
            fwd = 1;
            if (ma != 0) begin s.w0 = 1; q0.push_back('{ma, md}); end
         end else if (pw && !iw && pa != ma) begin
            fwd = 1;
            if (ma != 0) begin s.w1 = 1; q1.push_back('{ma, md}); end
         end
      end
`endif
      if (r) mq.delete();
      else begin
         if (cons) void'(mq.pop_front());
         else if (pend) mq[0].age = mq[0].age + 1;
         if (mv && s.rdy && !fwd) mq.push_back('{ma, md, 0});
      end
      st_q.push_back(s);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   // Monitor: compares status every cycle and port writes against the queues.
   always @(negedge clk) begin
      if (st_q.size() > 0) begin
         ms = st_q.pop_front();
         chk("m_ready", bus.m_ready, ms.rdy);
         chk("stall_req", bus.stall_req, ms.stall);
         chk("m_pending", bus.m_pending, ms.pend);
         chk("wen0", bus.wen0, ms.w0);
         chk("wen1", bus.wen1, ms.w1);
         if (ms.w0) begin
            mw = q0.pop_front();
            if (bus.wen0) begin
               chk("waddr0", bus.waddr0, mw.a);
               chk("wdata0", bus.wdata0, mw.d);
            end
         end
         if (ms.w1) begin
            mw = q1.pop_front();
            if (bus.wen1) begin
               chk("waddr1", bus.waddr1, mw.a);
               chk("wdata1", bus.wdata1, mw.d);
            end
         end
         if (bus.wen0 && bus.wen1) chk("port_addr_distinct", bus.waddr0 != bus.waddr1, 1);
         if (bus.wen0) rf[bus.waddr0] = bus.wdata0;
         if (bus.wen1) rf[bus.waddr1] = bus.wdata1;
      end
   end

   initial begin
      bit          pw, iw, mv, r;
      logic [4:0]  pa, ia, ma;
      for (int k = 0; k < 32; k++) rf[k] = 32'hDEADBEEF;
      bus.p_wen = 0; bus.p_waddr = 0; bus.p_wdata = 0;
      bus.i_wen = 0; bus.i_waddr = 0; bus.i_wdata = 0;
      bus.m_valid = 0; bus.m_waddr = 0; bus.m_wdata = 0;

      // Reset, then first cycle out of reset.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Basic drain: both ports busy at capture, r7 written next cycle.
      cyc(0, 1, 5, 32'h11, 1, 6, 32'h22, 1, 7, 32'h33);
      idle(2);
      settle();
      chk("rf_r7", rf[7], 32'h33);

      // Starvation: both ports busy until stall_req, then pipeline backs off.
      cyc(0, 1, 11, 32'h1, 1, 12, 32'h2, 1, 9, 32'h99);
      for (int k = 0; k < MW + 1; k++) cyc(0, 1, 11, k, 1, 12, k, 0, 0, 0);
      idle(3);
      settle();
      chk("rf_r9", rf[9], 32'h99);

      // Supersede: buffered r4 is overwritten by a newer pipeline write.
      cyc(0, 1, 20, 32'h5, 1, 21, 32'h6, 1, 4, 32'hAA);
      cyc(0, 1, 4, 32'hBB, 1, 22, 32'h7, 0, 0, 0);
      idle(3);
      settle();
      chk("rf_r4", rf[4], 32'hBB);

      // r0 result: accepted and consumed without a write.
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFF);
      idle(2);

      // Back-to-back multicycle results with free ports.
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h101);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h102);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h103);
      idle(2);
      settle();
      chk("rf_r1", rf[1], 32'h101);
      chk("rf_r2", rf[2], 32'h102);
      chk("rf_r3", rf[3], 32'h103);

      // Reset while r8 is held.
      cyc(0, 1, 23, 32'h8, 1, 24, 32'h9, 1, 8, 32'h88);
      cyc(0, 1, 25, 32'hA, 1, 26, 32'hB, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      settle();
      chk("rf_r8_untouched", rf[8], 32'hDEADBEEF);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 199) == 0);
         pw = ($urandom_range(0, 99) < 70);
         iw = ($urandom_range(0, 99) < 60);
         mv = ($urandom_range(0, 99) < 45);
         if (model_stall() && $urandom_range(0, 9) < 8) begin pw = 0; iw = 0; end
         if (r) begin pw = 0; iw = 0; mv = 0; end
         pa = 5'($urandom_range(0, 31));
         do ia = 5'($urandom_range(0, 31)); while (pw && iw && ia == pa);
         do ma = 5'($urandom_range(0, 31)); while ((pw && ma == pa) || (iw && ma == ia));
         cyc(r, pw, pa, $urandom, iw, ia, $urandom, mv, ma, $urandom);
      end
      idle(MW + 4);
      settle();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("model_empty", mq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
